// File: rtl/pedestrian_crossing_controller.sv
// Pedestrian signal head sequencer: DONT_WALK -> READY -> REQUEST -> WALK -> CLEAR.
// Handshakes with the vehicle controller so WALK only shows while cross traffic is held.
module pedestrian_crossing_controller #(
  parameter int unsigned WALK_TICKS          = 7,
  parameter int unsigned CLEAR_TICKS         = 10,
  parameter int unsigned MIN_DONT_WALK_TICKS = 5,
  parameter int unsigned CNT_W               = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       walk_button,
  input  logic       cars_stopped,
  output logic       ped_request,
  output logic [1:0] fsmHandControl,
  output logic       fsmPersonControl,
  output logic       blink,
  output logic       request_pending
);

  localparam logic [CNT_W-1:0] CNT_MAX        = '1;
  localparam logic [CNT_W-1:0] WALK_LAST      = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST     = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [CNT_W-1:0] DONT_WALK_LAST = CNT_W'(MIN_DONT_WALK_TICKS - 1);

  localparam logic [1:0] HAND_OFF   = 2'b00;
  localparam logic [1:0] HAND_SOLID = 2'b01;
  localparam logic [1:0] HAND_BLINK = 2'b10;

  typedef enum logic [2:0] {
    DONT_WALK = 3'd0,
    READY     = 3'd1,
    REQUEST   = 3'd2,
    WALK      = 3'd3,
    CLEAR     = 3'd4
  } state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] tickCnt, tickCntNext;
  logic             countEn;
  logic             pendingNext;
  logic [1:0]       handNext;
  logic             personNext, pedReqNext, blinkNext;

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= DONT_WALK;
      tickCnt          <= '0;
      request_pending  <= 1'b0;
      fsmHandControl   <= HAND_SOLID;
      fsmPersonControl <= 1'b0;
      blink            <= 1'b0;
      ped_request      <= 1'b0;
    end else begin
      state            <= stateNext;
      tickCnt          <= tickCntNext;
      request_pending  <= pendingNext;
      fsmHandControl   <= handNext;
      fsmPersonControl <= personNext;
      blink            <= blinkNext;
      ped_request      <= pedReqNext;
    end
  end

  // Next state plus the output values that state will show after the edge
  always_comb begin
    stateNext   = state;
    countEn     = 1'b0;
    tickCntNext = tickCnt;
    pendingNext = request_pending;
    handNext    = HAND_SOLID;
    personNext  = 1'b0;
    pedReqNext  = 1'b0;
    blinkNext   = 1'b0;

    case (state)
      DONT_WALK: begin
        countEn = 1'b1;
        if (tick && tickCnt == DONT_WALK_LAST) stateNext = READY;
      end
      READY: begin
        if (request_pending || walk_button) stateNext = REQUEST;
      end
      REQUEST: begin
        if (cars_stopped) stateNext = WALK;
      end
      WALK: begin
        countEn = 1'b1;
        if (tick && tickCnt == WALK_LAST) stateNext = CLEAR;
      end
      CLEAR: begin
        countEn = 1'b1;
        if (tick && tickCnt == CLEAR_LAST) stateNext = DONT_WALK;
      end
      default: stateNext = DONT_WALK;
    endcase

    // Transitions read the pre-increment count; entry always restarts from zero
    if (stateNext != state) begin
      tickCntNext = '0;
    end else if (countEn && tick && tickCnt != CNT_MAX) begin
      tickCntNext = tickCnt + CNT_W'(1);
    end

    // Presses during WALK are dropped; clearing on WALK entry overrides a same-cycle press
    if (walk_button && state != WALK) pendingNext = 1'b1;
    if (stateNext == WALK && state != WALK) pendingNext = 1'b0;

    case (stateNext)
      REQUEST: pedReqNext = 1'b1;
      WALK: begin
        handNext   = HAND_OFF;
        personNext = 1'b1;
        pedReqNext = 1'b1;
      end
      CLEAR: begin
        handNext   = HAND_BLINK;
        pedReqNext = 1'b1;
        if (state != CLEAR) blinkNext = 1'b1;
        else if (tick)      blinkNext = ~blink;
        else                blinkNext = blink;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pedestrian_crossing_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized stimulus against a countdown-based phase model.
module tb_pedestrian_crossing_controller;

  localparam int unsigned WALK_T  = 3;
  localparam int unsigned CLEAR_T = 4;
  localparam int unsigned MIN_T   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, walk_button, cars_stopped;
  logic       ped_request;
  logic [1:0] fsmHandControl;
  logic       fsmPersonControl, blink, request_pending;

  int nTests = 0;
  int nFail  = 0;

  pedestrian_crossing_controller #(
    .WALK_TICKS(WALK_T), .CLEAR_TICKS(CLEAR_T), .MIN_DONT_WALK_TICKS(MIN_T), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .walk_button(walk_button),
    .cars_stopped(cars_stopped), .ped_request(ped_request),
    .fsmHandControl(fsmHandControl), .fsmPersonControl(fsmPersonControl),
    .blink(blink), .request_pending(request_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       t, b, c;
    logic [1:0] hand;
    logic       person, ped, blk, pend;
  } vec_t;
  vec_t vq[$];

  // Reference model: phase name plus ticks remaining in that phase
  int mPhase;      // 0 don't-walk, 1 ready, 2 request, 3 walk, 4 clear
  int mLeft;
  int mClearDone;
  bit mPend;

  function automatic void modelReset();
    mPhase = 0; mLeft = MIN_T; mClearDone = 0; mPend = 0;
  endfunction

  function automatic void modelStep(bit t, bit b, bit c);
    int ph = mPhase;
    bit enterWalk = 0;
    case (ph)
      0: if (t) begin mLeft--; if (mLeft == 0) mPhase = 1; end
      1: if (mPend || b) mPhase = 2;
      2: if (c) begin mPhase = 3; mLeft = WALK_T; enterWalk = 1; end
      3: if (t) begin
           mLeft--;
           if (mLeft == 0) begin mPhase = 4; mLeft = CLEAR_T; mClearDone = 0; end
         end
      default: if (t) begin
           mLeft--; mClearDone++;
           if (mLeft == 0) begin mPhase = 0; mLeft = MIN_T; end
         end
    endcase
    if (b && ph != 3) mPend = 1;
    if (enterWalk) mPend = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkModel(input string tag);
    logic [1:0] eh;
    eh = (mPhase == 3) ? 2'b00 : (mPhase == 4) ? 2'b10 : 2'b01;
    chk({tag, ".hand"},   32'(fsmHandControl),   32'(eh));
    chk({tag, ".person"}, 32'(fsmPersonControl), 32'(mPhase == 3));
    chk({tag, ".ped"},    32'(ped_request),      32'(mPhase >= 2));
    chk({tag, ".blink"},  32'(blink),            32'(mPhase == 4 && (mClearDone % 2) == 0));
    chk({tag, ".pend"},   32'(request_pending),  32'(mPend));
  endtask

  task automatic chkReset(input string tag);
    chk({tag, ".hand"},   32'(fsmHandControl),   32'd1);
    chk({tag, ".person"}, 32'(fsmPersonControl), 32'd0);
    chk({tag, ".ped"},    32'(ped_request),      32'd0);
    chk({tag, ".blink"},  32'(blink),            32'd0);
    chk({tag, ".pend"},   32'(request_pending),  32'd0);
  endtask

  // Apply inputs at the falling edge, clock once, sample at the next falling edge
  task automatic step(input bit t, input bit b, input bit c);
    tick = t; walk_button = b; cars_stopped = c;
    @(posedge clk);
    modelStep(t, b, c);
    @(negedge clk);
  endtask

  task automatic addv(input bit t, b, c, input logic [1:0] h, input bit p, r, bl, pd);
    vec_t v;
    v = '{t: t, b: b, c: c, hand: h, person: p, ped: r, blk: bl, pend: pd};
    vq.push_back(v);
  endtask

  task automatic asyncReset(input string tag);
    #2 reset = 1'b1;
    #1 chkReset(tag);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int walkTicks, pendBad;
    bit t, done;

    reset = 1'b1; tick = 0; walk_button = 0; cars_stopped = 0;
    modelReset();
    repeat (2) @(negedge clk);
    chkReset("reset");
    reset = 1'b0;

    // t b c hand person ped blink pend (values after the edge)
    addv(1,0,0, 2'b01,0,0,0,0);
    addv(1,0,0, 2'b01,0,0,0,0);  // second tick: READY
    addv(0,0,0, 2'b01,0,0,0,0);
    addv(0,1,0, 2'b01,0,1,0,1);  // press in READY -> REQUEST
    addv(1,0,0, 2'b01,0,1,0,1);
    addv(0,0,1, 2'b00,1,1,0,0);  // cars stopped -> WALK, pending cleared
    addv(1,1,0, 2'b00,1,1,0,0);  // press in WALK ignored
    addv(0,1,0, 2'b00,1,1,0,0);
    addv(1,0,0, 2'b00,1,1,0,0);
    addv(1,0,0, 2'b10,0,1,1,0);  // third walk tick -> CLEAR, blink=1
    addv(0,0,0, 2'b10,0,1,1,0);
    addv(1,0,0, 2'b10,0,1,0,0);
    addv(1,1,0, 2'b10,0,1,1,1);  // press in CLEAR latches
    addv(1,0,0, 2'b10,0,1,0,1);
    addv(1,0,0, 2'b01,0,0,0,1);  // fourth clear tick -> DONT_WALK
    addv(1,0,0, 2'b01,0,0,0,1);
    addv(0,0,0, 2'b01,0,0,0,1);
    addv(1,0,0, 2'b01,0,0,0,1);  // READY
    addv(0,0,0, 2'b01,0,1,0,1);  // pending request served
    addv(0,0,1, 2'b00,1,1,0,0);
    addv(1,0,0, 2'b00,1,1,0,0);  // cars drop ignored mid-WALK

    foreach (vq[i]) begin
      step(vq[i].t, vq[i].b, vq[i].c);
      chk($sformatf("vec%0d.hand", i),   32'(fsmHandControl),   32'(vq[i].hand));
      chk($sformatf("vec%0d.person", i), 32'(fsmPersonControl), 32'(vq[i].person));
      chk($sformatf("vec%0d.ped", i),    32'(ped_request),      32'(vq[i].ped));
      chk($sformatf("vec%0d.blink", i),  32'(blink),            32'(vq[i].blk));
      chk($sformatf("vec%0d.pend", i),   32'(request_pending),  32'(vq[i].pend));
    end

    // Async reset mid-WALK, then the full don't-walk hold restarts
    asyncReset("midwalk_reset");
    step(1, 0, 0);
    chk("hold_after_reset.ped", 32'(ped_request), 32'd0);
    step(0, 1, 1);
    chk("hold_not_done.ped", 32'(ped_request), 32'd0);
    chk("press_latched.pend", 32'(request_pending), 32'd1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("request_after_hold.ped", 32'(ped_request), 32'd1);

    // REQUEST waits indefinitely for cars_stopped
    pendBad = 0;
    for (int i = 0; i < 50; i++) begin
      step(i % 10 == 9, 0, 0);
      if (ped_request !== 1'b1 || fsmPersonControl !== 1'b0) pendBad++;
    end
    chk("request_hold_50", 32'(pendBad), 32'd0);
    step(0, 0, 1);
    chk("walk_after_cars.person", 32'(fsmPersonControl), 32'd1);

    // Button held through WALK: no re-arm, no extension
    walkTicks = 0; pendBad = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      t = (i % 10 == 9);
      if (t) walkTicks++;
      step(t, 1, 0);
      if (request_pending !== 1'b0) pendBad++;
      if (fsmPersonControl !== 1'b1) done = 1;
    end
    chk("walk_exit_seen", 32'(done), 32'd1);
    chk("walk_tick_count", 32'(walkTicks), WALK_T);
    chk("walk_button_ignored", 32'(pendBad), 32'd0);
    chk("clear_entry.hand", 32'(fsmHandControl), 32'd2);
    chk("clear_entry.blink", 32'(blink), 32'd1);
    step(0, 1, 0);
    chk("clear_press.pend", 32'(request_pending), 32'd1);
    chkModel("directed_sync");

    // Randomized run against the model, with occasional mid-cycle resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(499) == 0) begin
        asyncReset("rand_reset");
      end else begin
        step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(2) != 0);
        chkModel("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
